tpu_matmul_top: RTL and testbench

//  APB-configured NxN matrix-multiply accelerator with three internal dual-port BRAMs (A, B, C).

---
 rtl/tpu_matmul_top.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_tpu_matmul_top.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_matmul_top.sv
// tpu_matmul_top: APB-configured NxN matrix-multiply engine with three
// dual-port BRAMs (A, B, C). The host loads A/B and reads C through the
// external ports; the engine computes C = A x B (optionally accumulating
// into the existing C) with row/column masking of the output tile.
// Build option: define OUT_SATURATE_EN to saturate output elements instead
// of truncating them to DWIDTH bits.

module tpu_matmul_bram #(
    parameter int unsigned AW = 10,
    parameter int unsigned WW = 32,
    parameter int unsigned N  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr_ext,
    input  logic [WW-1:0] wdata_ext,
    input  logic [N-1:0]  we_ext,
    output logic [WW-1:0] rdata_ext,
    input  logic [AW-1:0] addr_eng,
    input  logic [WW-1:0] wdata_eng,
    input  logic [N-1:0]  we_eng,
    output logic [WW-1:0] rdata_eng
);
    localparam int unsigned EW = WW / N;

    logic [WW-1:0] mem [0:(1<<AW)-1];

    // Per-element writes from both ports; the engine port wins a same-address collision
    always_ff @(posedge clk) begin
        for (int unsigned e = 0; e < N; e++) begin
            if (we_ext[e]) mem[addr_ext][e*EW +: EW] <= wdata_ext[e*EW +: EW];
            if (we_eng[e]) mem[addr_eng][e*EW +: EW] <= wdata_eng[e*EW +: EW];
        end
    end

    // Registered read-first data for both ports
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_ext <= '0;
            rdata_eng <= '0;
        end else begin
            rdata_ext <= mem[addr_ext];
            rdata_eng <= mem[addr_eng];
        end
    end
endmodule

module tpu_matmul_top #(
    parameter int unsigned DESIGN_SIZE   = 4,
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned AWIDTH        = 10,
    parameter int unsigned REG_ADDRWIDTH = 8,
    parameter int unsigned REG_DATAWIDTH = 32,
    parameter int unsigned ACC_W         = 2*DWIDTH+8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [REG_ADDRWIDTH-1:0]        PADDR,
    input  logic                            PWRITE,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic [REG_DATAWIDTH-1:0]        PWDATA,
    output logic [REG_DATAWIDTH-1:0]        PRDATA,
    output logic                            PREADY,
    input  logic [AWIDTH-1:0]               bram_addr_a_ext,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   bram_wdata_a_ext,
    input  logic [DESIGN_SIZE-1:0]          bram_we_a_ext,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   bram_rdata_a_ext,
    input  logic [AWIDTH-1:0]               bram_addr_b_ext,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   bram_wdata_b_ext,
    input  logic [DESIGN_SIZE-1:0]          bram_we_b_ext,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   bram_rdata_b_ext,
    input  logic [AWIDTH-1:0]               bram_addr_c_ext,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   bram_wdata_c_ext,
    input  logic [DESIGN_SIZE-1:0]          bram_we_c_ext,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   bram_rdata_c_ext
);
    localparam int unsigned N  = DESIGN_SIZE;
    localparam int unsigned WW = N * DWIDTH;
    localparam int unsigned CW = AWIDTH + 1;
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

    localparam logic [REG_ADDRWIDTH-1:0] A_CTRL   = 'h00;
    localparam logic [REG_ADDRWIDTH-1:0] A_STATUS = 'h04;
    localparam logic [REG_ADDRWIDTH-1:0] A_K      = 'h08;
    localparam logic [REG_ADDRWIDTH-1:0] A_BASEA  = 'h0C;
    localparam logic [REG_ADDRWIDTH-1:0] A_BASEB  = 'h10;
    localparam logic [REG_ADDRWIDTH-1:0] A_BASEC  = 'h14;
    localparam logic [REG_ADDRWIDTH-1:0] A_SHIFT  = 'h18;
    localparam logic [REG_ADDRWIDTH-1:0] A_DIMS   = 'h1C;

`ifdef OUT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DWIDTH-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;
    state_t state, state_next;

    logic                     apb_wr, apb_rd, start, busy, done, ctrl_acc;
    logic [CW-1:0]            k_reg, k_last, cnt;
    logic [AWIDTH-1:0]        base_a, base_b, base_c, eng_addr_a, eng_addr_b, eng_addr_c;
    logic [4:0]               shift, m_eff, n_eff;
    logic [7:0]               dims;
    logic [REG_DATAWIDTH-1:0] rd_val;
    logic                     pre_vld, mac_vld;
    logic [RW-1:0]            rd_row, wr_row;
    logic [WW-1:0]            a_rdata, b_rdata, c_rdata, eng_wdata_c;
    logic [N-1:0]             eng_we_c, col_mask;
    logic signed [ACC_W-1:0]  a_ext [N];
    logic signed [ACC_W-1:0]  b_ext [N];
    logic signed [ACC_W-1:0]  c_ext [N];
    logic signed [ACC_W-1:0]  shifted [N];
    logic signed [ACC_W-1:0]  prod [N][N];
    logic signed [ACC_W-1:0]  acc [N][N];
    logic                     unused_pwdata;

    assign apb_wr = PSEL & PENABLE & PWRITE;
    assign apb_rd = PSEL & PENABLE & ~PWRITE;
    assign start  = apb_wr && (PADDR == A_CTRL) && PWDATA[0];
    assign PREADY = 1'b1;
    assign k_last = (k_reg == '0) ? '0 : k_reg - CW'(1);
    assign m_eff  = (dims[3:0] == 4'd0 || dims[3:0] > 4'(N)) ? 5'(N) : {1'b0, dims[3:0]};
    assign n_eff  = (dims[7:4] == 4'd0 || dims[7:4] > 4'(N)) ? 5'(N) : {1'b0, dims[7:4]};
    assign wr_row = cnt[RW-1:0];
    assign unused_pwdata = ^PWDATA[REG_DATAWIDTH-1:CW];

    // Configuration registers written in the APB access phase
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_acc <= 1'b0;
            k_reg    <= '0;
            base_a   <= '0;
            base_b   <= '0;
            base_c   <= '0;
            shift    <= '0;
            dims     <= '0;
        end else if (apb_wr) begin
            case (PADDR)
                A_CTRL:  ctrl_acc <= PWDATA[1];
                A_K:     k_reg    <= PWDATA[CW-1:0];
                A_BASEA: base_a   <= PWDATA[AWIDTH-1:0];
                A_BASEB: base_b   <= PWDATA[AWIDTH-1:0];
                A_BASEC: base_c   <= PWDATA[AWIDTH-1:0];
                A_SHIFT: shift    <= PWDATA[4:0];
                A_DIMS:  dims     <= PWDATA[7:0];
                default: ;
            endcase
        end
    end

    // Sticky done: set on completion, cleared by an accepted start or write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset)                                         done <= 1'b0;
        else if (state == S_DONE)                          done <= 1'b1;
        else if (state == S_IDLE && start)                 done <= 1'b0;
        else if (apb_wr && PADDR == A_STATUS && PWDATA[0]) done <= 1'b0;
    end

    // Register read mux; start bit always reads back as 0
    always_comb begin
        rd_val = '0;
        case (PADDR)
            A_CTRL:   rd_val[1]          = ctrl_acc;
            A_STATUS: rd_val[1:0]        = {busy, done};
            A_K:      rd_val[CW-1:0]     = k_reg;
            A_BASEA:  rd_val[AWIDTH-1:0] = base_a;
            A_BASEB:  rd_val[AWIDTH-1:0] = base_b;
            A_BASEC:  rd_val[AWIDTH-1:0] = base_c;
            A_SHIFT:  rd_val[4:0]        = shift;
            A_DIMS:   rd_val[7:0]        = dims;
            default:  ;
        endcase
    end

    // PRDATA captured on the read access edge and held until the next read
    always_ff @(posedge clk) begin
        if (reset)       PRDATA <= '0;
        else if (apb_rd) PRDATA <= rd_val;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic; the accumulate bit is taken from the same write that starts
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = PWDATA[1] ? S_PRELOAD : S_MAC;
            S_PRELOAD: if (cnt == CW'(N)) state_next = S_MAC;
            S_MAC:     if (cnt == k_last) state_next = S_DRAIN;
            S_DRAIN:   state_next = S_WRITE;
            S_WRITE:   if (cnt == CW'(N-1)) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and engine-side BRAM controls
    always_comb begin
        busy       = (state == S_PRELOAD) || (state == S_MAC) || (state == S_DRAIN) || (state == S_WRITE);
        eng_addr_a = base_a + cnt[AWIDTH-1:0];
        eng_addr_b = base_b + cnt[AWIDTH-1:0];
        eng_addr_c = base_c + cnt[AWIDTH-1:0];
        eng_we_c   = '0;
        if (state == S_WRITE && !reset && 5'(wr_row) < m_eff) eng_we_c = col_mask;
    end

    // Step counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (reset)                    cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else                          cnt <= cnt + CW'(1);
    end

    // Read-data valid flags, one cycle behind the issued BRAM address
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_vld <= 1'b0;
            mac_vld <= 1'b0;
            rd_row  <= '0;
        end else begin
            pre_vld <= (state == S_PRELOAD) && (cnt < CW'(N));
            mac_vld <= (state == S_MAC);
            rd_row  <= cnt[RW-1:0];
        end
    end

    // Element unpacking, outer products, output shift/reduction and column mask
    always_comb begin
        eng_wdata_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            a_ext[i] = ACC_W'($signed(a_rdata[i*DWIDTH +: DWIDTH]));
            b_ext[i] = ACC_W'($signed(b_rdata[i*DWIDTH +: DWIDTH]));
            c_ext[i] = ACC_W'($signed(c_rdata[i*DWIDTH +: DWIDTH]));
        end
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
                prod[i][j] = a_ext[i] * b_ext[j];
        for (int unsigned j = 0; j < N; j++) begin
            col_mask[j] = 5'(j) < n_eff;
            shifted[j]  = acc[wr_row][j] >>> shift;
`ifdef OUT_SATURATE_EN
            if (shifted[j] > SAT_MAX)      eng_wdata_c[j*DWIDTH +: DWIDTH] = SAT_MAX[DWIDTH-1:0];
            else if (shifted[j] < SAT_MIN) eng_wdata_c[j*DWIDTH +: DWIDTH] = SAT_MIN[DWIDTH-1:0];
            else                           eng_wdata_c[j*DWIDTH +: DWIDTH] = shifted[j][DWIDTH-1:0];
`else
            eng_wdata_c[j*DWIDTH +: DWIDTH] = shifted[j][DWIDTH-1:0];
`endif
        end
    end

    // Accumulator array: cleared on start, loaded by preload, updated by MAC data
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && start)) begin
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < N; j++)
                    acc[i][j] <= '0;
        end else if (pre_vld) begin
            for (int unsigned j = 0; j < N; j++)
                acc[rd_row][j] <= c_ext[j];
        end else if (mac_vld) begin
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < N; j++)
                    acc[i][j] <= acc[i][j] + prod[i][j];
        end
    end

    tpu_matmul_bram #(.AW(AWIDTH), .WW(WW), .N(N)) u_bram_a (
        .clk(clk), .reset(reset),
        .addr_ext(bram_addr_a_ext), .wdata_ext(bram_wdata_a_ext), .we_ext(bram_we_a_ext), .rdata_ext(bram_rdata_a_ext),
        .addr_eng(eng_addr_a), .wdata_eng('0), .we_eng('0), .rdata_eng(a_rdata)
    );

    tpu_matmul_bram #(.AW(AWIDTH), .WW(WW), .N(N)) u_bram_b (
        .clk(clk), .reset(reset),
        .addr_ext(bram_addr_b_ext), .wdata_ext(bram_wdata_b_ext), .we_ext(bram_we_b_ext), .rdata_ext(bram_rdata_b_ext),
        .addr_eng(eng_addr_b), .wdata_eng('0), .we_eng('0), .rdata_eng(b_rdata)
    );

    tpu_matmul_bram #(.AW(AWIDTH), .WW(WW), .N(N)) u_bram_c (
        .clk(clk), .reset(reset),
        .addr_ext(bram_addr_c_ext), .wdata_ext(bram_wdata_c_ext), .we_ext(bram_we_c_ext), .rdata_ext(bram_rdata_c_ext),
        .addr_eng(eng_addr_c), .wdata_eng(eng_wdata_c), .we_eng(eng_we_c), .rdata_eng(c_rdata)
    );
endmodule

// File: tb/tb_tpu_matmul_top.sv
// Testbench for tpu_matmul_top: directed register/matmul scenarios plus
// randomized operations checked against an array-based matrix model.
module tb_tpu_matmul_top;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    PADDR;
    logic          PWRITE, PSEL, PENABLE, PREADY;
    logic [31:0]   PWDATA, PRDATA;
    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic [31:0]   wdata_a, wdata_b, wdata_c, rdata_a, rdata_b, rdata_c;
    logic [3:0]    we_a, we_b, we_c;

    always #5 clk = ~clk;

    tpu_matmul_top #(
        .DESIGN_SIZE(N), .DWIDTH(DW), .AWIDTH(AW), .REG_ADDRWIDTH(8), .REG_DATAWIDTH(32), .ACC_W(2*DW+8)
    ) dut (
        .clk(clk), .reset(reset),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY),
        .bram_addr_a_ext(addr_a), .bram_wdata_a_ext(wdata_a), .bram_we_a_ext(we_a), .bram_rdata_a_ext(rdata_a),
        .bram_addr_b_ext(addr_b), .bram_wdata_b_ext(wdata_b), .bram_we_b_ext(we_b), .bram_rdata_b_ext(rdata_b),
        .bram_addr_c_ext(addr_c), .bram_wdata_c_ext(wdata_c), .bram_we_c_ext(we_c), .bram_rdata_c_ext(rdata_c)
    );

    int checks = 0;
    int errors = 0;

    // model[0]=A, model[1]=B, model[2]=C; [word][element]
    logic [7:0] model [3][1024][4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
        data = PRDATA;
    endtask

    task automatic bram_write(input int which, input int addr, input logic [31:0] w);
        int a;
        a = addr % 1024;
        @(negedge clk);
        case (which)
            0:       begin addr_a = a[AW-1:0]; wdata_a = w; we_a = 4'hF; end
            1:       begin addr_b = a[AW-1:0]; wdata_b = w; we_b = 4'hF; end
            default: begin addr_c = a[AW-1:0]; wdata_c = w; we_c = 4'hF; end
        endcase
        @(negedge clk);
        we_a = 4'h0; we_b = 4'h0; we_c = 4'h0;
        for (int e = 0; e < N; e++) model[which][a][e] = w[e*8 +: 8];
    endtask

    task automatic bram_read(input int which, input int addr, output logic [31:0] w);
        int a;
        a = addr % 1024;
        @(negedge clk);
        case (which)
            0:       addr_a = a[AW-1:0];
            1:       addr_b = a[AW-1:0];
            default: addr_c = a[AW-1:0];
        endcase
        @(posedge clk);
        #1;
        case (which)
            0:       w = rdata_a;
            1:       w = rdata_b;
            default: w = rdata_c;
        endcase
    endtask

    function automatic logic [31:0] model_word(input int which, input int addr);
        logic [31:0] w;
        for (int e = 0; e < N; e++) w[e*8 +: 8] = model[which][addr % 1024][e];
        return w;
    endfunction

    function automatic logic [7:0] reduce(input int v);
        logic [7:0] r;
        r = v[7:0];
`ifdef OUT_SATURATE_EN
        if (v > 127)  r = 8'h7F;
        if (v < -128) r = 8'h80;
`endif
        return r;
    endfunction

    // Reference: C = (accum ? C : 0) + A x B, shifted, reduced, masked by M/N
    task automatic predict(input bit accum, input int k, input int sh, input int dims,
                           input int ba, input int bb, input int bc);
        int m, n, acc_v, av, bv;
        logic [7:0] nrow [4][4];
        m = dims & 15;        if (m == 0 || m > N) m = N;
        n = (dims >> 4) & 15; if (n == 0 || n > N) n = N;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nrow[i][j] = model[2][(bc + i) % 1024][j];
                if (i < m && j < n) begin
                    acc_v = 0;
                    if (accum) begin
                        av = $signed(model[2][(bc + i) % 1024][j]);
                        acc_v = av;
                    end
                    for (int kk = 0; kk < k; kk++) begin
                        av = $signed(model[0][(ba + kk) % 1024][i]);
                        bv = $signed(model[1][(bb + kk) % 1024][j]);
                        acc_v += av * bv;
                    end
                    nrow[i][j] = reduce(acc_v >>> sh);
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                model[2][(bc + i) % 1024][j] = nrow[i][j];
    endtask

    task automatic set_regs(input int k, input int sh, input int dims, input int ba, input int bb, input int bc);
        apb_write(8'h08, k);
        apb_write(8'h0C, ba);
        apb_write(8'h10, bb);
        apb_write(8'h14, bc);
        apb_write(8'h18, sh);
        apb_write(8'h1C, dims);
    endtask

    task automatic check_c_rows(input int bc, input string tag);
        logic [31:0] w;
        for (int i = 0; i < N; i++) begin
            bram_read(2, bc + i, w);
            check($sformatf("%s_row%0d", tag, i), w, model_word(2, bc + i));
        end
    endtask

    task automatic run_op(input int k, input bit accum, input int sh, input int dims,
                          input int ba, input int bb, input int bc, input string tag);
        logic [31:0] st;
        set_regs(k, sh, dims, ba, bb, bc);
        apb_write(8'h00, accum ? 32'h3 : 32'h1);
        st = '0;
        for (int p = 0; p < 300 && st[0] !== 1'b1; p++) apb_read(8'h04, st);
        check({tag, "_status"}, st, 32'h1);
        predict(accum, k, sh, dims, ba, bb, bc);
        check_c_rows(bc, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        addr_a = '0; addr_b = '0; addr_c = '0; wdata_a = '0; wdata_b = '0; wdata_c = '0;
        we_a = '0; we_b = '0; we_c = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", {31'b0, PREADY}, 32'h1);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_rdata_c", rdata_c, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Register access
        apb_read(8'h04, w); check("rst_status", w, 32'h0);
        apb_read(8'h1C, w); check("rst_dims", w, 32'h0);
        apb_write(8'h08, 32'd5);
        apb_write(8'h18, 32'd3);
        apb_write(8'h40, 32'hFFFF_FFFF);
        apb_read(8'h08, w); check("reg_k", w, 32'd5);
        apb_read(8'h18, w); check("reg_shift", w, 32'd3);
        apb_read(8'h40, w); check("reg_unmapped", w, 32'h0);

        // Identity A, B row k = {k+1..k+4}
        for (int k = 0; k < N; k++) begin
            w = '0;
            w[k*8 +: 8] = 8'd1;
            bram_write(0, k, w);
            for (int j = 0; j < N; j++) w[j*8 +: 8] = 8'(k + 1 + j);
            bram_write(1, k, w);
        end
        run_op(4, 1'b0, 0, 0, 0, 0, 0, "layer");
        bram_read(2, 1, w); check("layer_row1_const", w, 32'h05040302);
        apb_write(8'h04, 32'h1);
        apb_read(8'h04, w); check("status_w1c", w, 32'h0);

        // Accumulate into C preloaded with ones
        for (int i = 0; i < N; i++) bram_write(2, i, 32'h01010101);
        run_op(4, 1'b1, 0, 0, 0, 0, 0, "accum");
        bram_read(2, 2, w); check("accum_row2_const", w, 32'h07060504);

        // Masked 3x3 tile
        for (int i = 0; i < N; i++) begin
            bram_write(2, i, 32'hAAAAAAAA);
            bram_write(1, i, 32'h02020202);
        end
        run_op(4, 1'b0, 0, 8'h33, 0, 0, 0, "npo2");
        bram_read(2, 0, w); check("npo2_row0_const", w, 32'hAA020202);
        bram_read(2, 3, w); check("npo2_row3_const", w, 32'hAAAAAAAA);

        // Output reduction of 4*127*127
        for (int i = 0; i < N; i++) begin
            bram_write(0, i, 32'h7F7F7F7F);
            bram_write(1, i, 32'h7F7F7F7F);
        end
        run_op(4, 1'b0, 0, 0, 0, 0, 0, "sat");
        bram_read(2, 0, w);
`ifdef OUT_SATURATE_EN
        check("sat_row0_const", w, 32'h7F7F7F7F);
`else
        check("sat_row0_const", w, 32'h04040404);
`endif

        // Reset in the middle of a long MAC phase
        set_regs(100, 0, 0, 0, 0, 0);
        apb_write(8'h00, 32'h1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        apb_read(8'h04, w); check("midrst_status", w, 32'h0);
        apb_read(8'h08, w); check("midrst_k", w, 32'h0);
        check_c_rows(0, "midrst_keep");
        for (int i = 0; i < N; i++) bram_write(0, i + 8, $urandom);
        run_op(4, 1'b0, 1, 0, 8, 0, 0, "after_rst");

        // Randomized operations with wrapping base addresses
        for (int r = 0; r < 10; r++) begin
            int k, ba, bb, bc, sh, dims;
            bit accum;
            k     = $urandom_range(1, 8);
            ba    = $urandom_range(0, 1023);
            bb    = $urandom_range(0, 1023);
            bc    = $urandom_range(0, 1023);
            sh    = $urandom_range(0, 4);
            dims  = $urandom_range(0, 255);
            accum = 1'($urandom_range(0, 1));
            for (int i = 0; i < k; i++) begin
                bram_write(0, ba + i, $urandom);
                bram_write(1, bb + i, $urandom);
            end
            for (int i = 0; i < N; i++) bram_write(2, bc + i, $urandom);
            run_op(k, accum, sh, dims, ba, bb, bc, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
